// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
//
// Round-robin arbiter that lets two masters share one single-port memory with
// a valid/ready handshake and registered read data. One request is in flight
// at a time. A winning request is latched onto the memory pins, held there
// until the memory answers (or a timeout expires), and the outcome is returned
// to the owner as a one-cycle response pulse.
//
// Ports
//   clk_i                    clock, rising edge
//   rst_i                    asynchronous reset, active-low
//   req_valid{0,1}_i         requester k has a pending request
//   req_wr_rd_en{0,1}_i      1 = write, 0 = read
//   req_addr{0,1}_i          request address
//   req_wdata{0,1}_i         request write data
//   req_ready{0,1}_o         request accepted this cycle (combinational, IDLE)
//   resp_valid{0,1}_o        one-cycle completion pulse
//   resp_err{0,1}_o          completion was a timeout abort
//   resp_rdata{0,1}_o        read data (0 for writes/aborts), held until the
//                            requester's next response
//   mem_valid_o              memory request valid (registered)
//   mem_wr_rd_en_o           memory write/read select (registered)
//   mem_addr_o               memory address (registered)
//   mem_wdata_o              memory write data (registered)
//   mem_ready_i              memory ready, only looked at in ISSUE
//   mem_rdata_i              memory read data, only looked at in ISSUE
//   busy_o                   arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_rr_arbiter #(
  parameter int WIDTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  req_valid0_i,
  input  logic                  req_wr_rd_en0_i,
  input  logic [ADDR_WIDTH-1:0] req_addr0_i,
  input  logic [WIDTH-1:0]      req_wdata0_i,
  output logic                  req_ready0_o,
  output logic                  resp_valid0_o,
  output logic                  resp_err0_o,
  output logic [WIDTH-1:0]      resp_rdata0_o,

  input  logic                  req_valid1_i,
  input  logic                  req_wr_rd_en1_i,
  input  logic [ADDR_WIDTH-1:0] req_addr1_i,
  input  logic [WIDTH-1:0]      req_wdata1_i,
  output logic                  req_ready1_o,
  output logic                  resp_valid1_o,
  output logic                  resp_err1_o,
  output logic [WIDTH-1:0]      resp_rdata1_o,

  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,

  output logic                  busy_o
);

  // Wide enough to hold TIMEOUT_CYCLES-1 for any legal TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             owner_q;       // requester that owns the in-flight access
  logic             last_grant_q;  // owner of the most recent accepted request
  logic [CNT_W-1:0] cnt_q;         // cycles spent in ISSUE

  // Grant selection (IDLE only)
  logic                  grant_vld;
  logic                  grant_id;
  logic                  sel_wr_rd_en;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;

  // ISSUE completion conditions
  logic             issue_ok;
  logic             issue_to;
  logic             issue_end;
  logic [WIDTH-1:0] resp_data_d;

  // ---------------------------------------------------------------------------
  // Round-robin grant: a lone requester always wins; on a tie the requester
  // that did not win last time gets it.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_vld = req_valid0_i | req_valid1_i;
    grant_id  = 1'b0;
    if (req_valid0_i && req_valid1_i) begin
      grant_id = ~last_grant_q;
    end else if (req_valid1_i) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    sel_wr_rd_en = req_wr_rd_en0_i;
    sel_addr     = req_addr0_i;
    sel_wdata    = req_wdata0_i;
    if (grant_id) begin
      sel_wr_rd_en = req_wr_rd_en1_i;
      sel_addr     = req_addr1_i;
      sel_wdata    = req_wdata1_i;
    end
  end

  // A ready on the timeout edge still counts as a normal completion, so the
  // timeout term is qualified with !mem_ready_i.
  always_comb begin
    issue_ok  = (state_q == S_ISSUE) && mem_ready_i;
    issue_to  = (state_q == S_ISSUE) && !mem_ready_i && (cnt_q == CNT_LAST);
    issue_end = issue_ok || issue_to;
    resp_data_d = '0;
    if (issue_ok && !mem_wr_rd_en_o) begin
      resp_data_d = mem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_ISSUE;
      S_ISSUE: if (issue_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready0_o = 1'b0;
    req_ready1_o = 1'b0;
    busy_o       = (state_q != S_IDLE);
    if (state_q == S_IDLE && grant_vld) begin
      req_ready0_o = ~grant_id;
      req_ready1_o =  grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Request stage: memory request pins and arbitration bookkeeping.
  // Cleared asynchronously so a reset mid-access drops mem_valid_o at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      mem_valid_o    <= 1'b0;
      mem_wr_rd_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            mem_valid_o    <= 1'b1;
            mem_wr_rd_en_o <= sel_wr_rd_en;
            mem_addr_o     <= sel_addr;
            mem_wdata_o    <= sel_wdata;
            owner_q        <= grant_id;
            last_grant_q   <= grant_id;
            cnt_q          <= '0;
          end
        end
        S_ISSUE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (issue_end) begin
            mem_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response stage: one-cycle pulse to the owner; read data is held per
  // requester until that requester's next completion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_valid0_o <= 1'b0;
      resp_err0_o   <= 1'b0;
      resp_rdata0_o <= '0;
      resp_valid1_o <= 1'b0;
      resp_err1_o   <= 1'b0;
      resp_rdata1_o <= '0;
    end else begin
      if (issue_end) begin
        if (owner_q) begin
          resp_valid1_o <= 1'b1;
          resp_err1_o   <= issue_to;
          resp_rdata1_o <= resp_data_d;
        end else begin
          resp_valid0_o <= 1'b1;
          resp_err0_o   <= issue_to;
          resp_rdata0_o <= resp_data_d;
        end
      end else if (state_q == S_DONE) begin
        resp_valid0_o <= 1'b0;
        resp_err0_o   <= 1'b0;
        resp_valid1_o <= 1'b0;
        resp_err1_o   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares a single-port handshaked memory (valid/ready, one wr_rd_en select, registered read data) between two masters. It accepts one request at a time, drives the memory valid/ready handshake, and returns read data or a write acknowledge to the winning requester. It guards against a hung memory with a timeout. It sits between the two masters and the memory, and is the only driver of the memory request pins.

Parameters:
WIDTH, 16, data width; must match memory WIDTH
ADDR_WIDTH, 4, address width; must match memory ADDR_WIDTH
TIMEOUT_CYCLES, 15, max cycles in ISSUE without mem_ready_i before abort (>=2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low (0 = reset)
req_valid0_i / req_valid1_i  input  1  requester k has a pending request
req_wr_rd_en0_i / req_wr_rd_en1_i  input  1  1 = write, 0 = read
req_addr0_i / req_addr1_i  input  ADDR_WIDTH  request address
req_wdata0_i / req_wdata1_i  input  WIDTH  write data
req_ready0_o / req_ready1_o  output  1  request accepted (combinational, IDLE only)
resp_valid0_o / resp_valid1_o  output  1  one-cycle completion pulse
resp_err0_o / resp_err1_o  output  1  qualifies resp_valid: timeout abort
resp_rdata0_o / resp_rdata1_o  output  WIDTH  read data, valid with resp_valid
mem_valid_o  output  1  memory request valid (registered)
mem_wr_rd_en_o  output  1  memory write/read select (registered)
mem_addr_o  output  ADDR_WIDTH  memory address (registered)
mem_wdata_o  output  WIDTH  memory write data (registered)
mem_ready_i  input  1  memory ready
mem_rdata_i  input  WIDTH  memory read data
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i=0, takes effect asynchronously): state IDLE. All outputs are 0, except req_readyk_o, which follows the IDLE grant logic. last_grant=1, so requester 0 wins the first tie. Timeout counter is 0. Reset mid-transaction drops mem_valid_o immediately, and no response is issued.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = the requester != last_grant.
  - req_ready_grant_o = 1 combinationally. The other requester's ready = 0.
  - On a clock edge with a grant: latch wr_rd_en/addr/wdata into mem_*_o and set mem_valid_o=1. Record the owner, set last_grant=owner, clear the counter, go to ISSUE.
- ISSUE:
  - mem_valid_o is held at 1 with stable fields. The counter increments each cycle.
  - Edge with mem_ready_i=1:
    - Capture mem_rdata_i into resp_rdata_owner_o for a read, or 0 for a write.
    - Set resp_valid_owner_o=1, clear mem_valid_o, go to DONE.
  - Edge with mem_ready_i=0 and counter==TIMEOUT_CYCLES-1:
    - Set resp_valid_owner_o=1, resp_err_owner_o=1, resp_rdata=0, clear mem_valid_o, go to DONE.
  - ready and timeout on the same edge: ready wins (no error).
- DONE: resp pulse is visible for exactly this one cycle. mem_ready_i is ignored here, because the memory's ready can remain high one cycle after valid drops. Next edge: clear resp_valid/resp_err and go to IDLE. No request is accepted in DONE.
- mem_ready_i and mem_rdata_i are ignored outside ISSUE; X on them after memory power-up is harmless.
- Latency: accept edge T, mem_valid_o high from T. Memory samples at T+1, and ready is seen at T+2. resp_valid is high in the cycle T+2..T+3. The earliest next accept is edge T+4. A single transaction occupies 4 cycles; back-to-back throughput is one per 4 cycles.
- Fairness: when both requesters are continuously valid, grants strictly alternate 0,1,0,1.
- resp_rdata holds its value until that requester's next response. A requester may drop req_valid without acceptance; there is no penalty and no state change.

Test Plan:
- Reset, then req_valid0=1 write addr=3 wdata=16'hA5A5 -> req_ready0 high in cycle 0; mem_valid_o high 2 cycles with addr 3; resp_valid0 pulse at cycle 2 with err=0 and rdata=0.
- After the write above, requester 1 reads addr=3 -> resp_valid1 pulse with resp_rdata1_o=16'hA5A5; resp_rdata0 unchanged.
- Both valid continuously for 6 transactions from reset -> grant order 0,1,0,1,0,1; each response arrives 2 cycles after its accept; accepts are 4 cycles apart.
- Tie mem_ready_i=0, requester 0 reads -> mem_valid_o high for exactly TIMEOUT_CYCLES=15 cycles; resp_valid0=resp_err0=1 for one cycle with rdata=0; back in IDLE.
- Assert mem_ready_i exactly on the timeout edge -> response has err=0 and carries mem_rdata_i.
- Pull rst_i low one cycle after an accept -> mem_valid_o falls without waiting for a clock; no resp_valid; after release, requester 0 wins the tie.
